// File: rtl/fb_scanout_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fb_scanout_if                                                   |
// | Purpose  : Frame-buffer read port plus the valid/ready pixel stream used   |
// |            by fb_scanout. master = scanout side, slave = memory/sink side. |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface fb_scanout_if #(
  parameter int FB_ADDR_W = 19,
  parameter int COLOR_W   = 24
);
  logic                 fb_rd_en;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [COLOR_W-1:0]   fb_rd_data;
  logic                 px_valid;
  logic                 px_ready;
  logic [COLOR_W-1:0]   px_data;
  logic                 px_sof;
  logic                 px_eol;
  logic                 px_eof;

  modport master (
    output fb_rd_en, fb_addr,
    input  fb_rd_data,
    output px_valid, px_data, px_sof, px_eol, px_eof,
    input  px_ready
  );

  modport slave (
    input  fb_rd_en, fb_addr,
    output fb_rd_data,
    input  px_valid, px_data, px_sof, px_eol, px_eof,
    output px_ready
  );
endinterface
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fb_scanout                                                      |
// | Purpose  : Reads one frame from the frame buffer in raster order, hides    |
// |            the fixed read latency with a credit-limited prefetch FIFO and  |
// |            emits a valid/ready pixel stream with sof/eol/eof markers.      |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module fb_scanout #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FB_ADDR_W  = 19,
  parameter int COLOR_W    = 24,
  parameter int RD_LAT     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  fb_scanout_if.master bus,
  output logic         busy,
  output logic         frame_done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int X_W   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int Y_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [X_W-1:0]       LAST_X    = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]       LAST_Y    = Y_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0]     DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [FB_ADDR_W-1:0] rd_count;
  logic [RD_LAT-1:0]    vpipe, vpipe_nxt;
  logic [CNT_W-1:0]     inflight;
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [COLOR_W-1:0]   mem [FIFO_DEPTH];
  logic [X_W-1:0]       out_x;
  logic [Y_W-1:0]       out_y;
  logic                 rd_en, credit_ok, push, pop, px_valid, px_eol, px_eof;

  // Reads still travelling through the memory pipe hold a FIFO slot in reserve.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(vpipe[i]);
  end

  assign credit_ok = (inflight + count) < DEPTH_C;
  assign push      = vpipe[RD_LAT-1];
  assign px_valid  = (count != '0);
  assign pop       = px_valid && bus.px_ready;
  assign px_eol    = px_valid && (out_x == LAST_X);
  assign px_eof    = px_eol && (out_y == LAST_Y);

  // Valid pipe marking which cycles carry returned read data.
  generate
    if (RD_LAT == 1) begin : g_vpipe_one
      assign vpipe_nxt = rd_en;
    end else begin : g_vpipe_shift
      assign vpipe_nxt = {vpipe[RD_LAT-2:0], rd_en};
    end
  endgenerate

  // Frame sequencing state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, read strobe and status outputs.
  always_comb begin
    state_nxt  = state;
    rd_en      = 1'b0;
    frame_done = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE:  if (start) state_nxt = S_SCAN;
      S_SCAN: begin
        rd_en = credit_ok;
        if (credit_ok && (rd_count == LAST_ADDR)) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (pop && px_eof) state_nxt = S_DONE;
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address counter, latency pipe, FIFO bookkeeping and output position.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      vpipe    <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_x    <= '0;
      out_y    <= '0;
    end else begin
      vpipe <= vpipe_nxt;
      if ((state == S_IDLE) && start) begin
        rd_count <= '0;
        out_x    <= '0;
        out_y    <= '0;
      end else begin
        if (rd_en) rd_count <= rd_count + FB_ADDR_W'(1);
        if (pop) begin
          if (out_x == LAST_X) begin
            out_x <= '0;
            out_y <= (out_y == LAST_Y) ? '0 : out_y + Y_W'(1);
          end else begin
            out_x <= out_x + X_W'(1);
          end
        end
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.fb_rd_data;
  end

  // The credit rule must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && (count == DEPTH_C)));
  end

  assign bus.fb_rd_en = rd_en;
  assign bus.fb_addr  = rd_count;
  assign bus.px_valid = px_valid;
  assign bus.px_data  = px_valid ? mem[rd_ptr] : '0;
  assign bus.px_sof   = px_valid && (out_x == '0) && (out_y == '0);
  assign bus.px_eol   = px_eol;
  assign bus.px_eof   = px_eof;
endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fb_scanout                                                   |
// | Purpose  : Self-checking bench for fb_scanout: frame-level reference of    |
// |            addresses, pixels, markers, credits, busy and frame_done.       |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_fb_scanout;
  localparam int WIDTH      = 4;
  localparam int HEIGHT     = 2;
  localparam int RD_LAT     = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int FB_ADDR_W  = 19;
  localparam int COLOR_W    = 24;
  localparam int TOTAL      = WIDTH * HEIGHT;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic busy, frame_done;

  fb_scanout_if #(.FB_ADDR_W(FB_ADDR_W), .COLOR_W(COLOR_W)) bus ();

  fb_scanout #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FB_ADDR_W(FB_ADDR_W), .COLOR_W(COLOR_W),
    .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Frame-buffer model: returns addr + 0x100 exactly RD_LAT cycles after the read.
  logic [FB_ADDR_W-1:0] mem_addr [RD_LAT];
  always @(posedge clk) begin
    mem_addr[0] <= bus.fb_addr;
    for (int i = 1; i < RD_LAT; i++) mem_addr[i] <= mem_addr[i-1];
  end
  assign bus.fb_rd_data = COLOR_W'(mem_addr[RD_LAT-1]) + COLOR_W'(32'h100);

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state: what the frame should look like so far.
  bit busy_m, done_m, prev_stall, saw_done;
  int iss, popd, first_rd, last_rd, first_valid, first_pop, last_pop;
  logic [COLOR_W-1:0] prev_data;
  logic [2:0]         prev_mk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_model_clear();
    iss = 0; popd = 0; first_rd = -1; last_rd = -1;
    first_valid = -1; first_pop = -1; last_pop = -1;
  endtask

  task automatic reset_model();
    busy_m = 0; done_m = 0; prev_stall = 0; saw_done = 0;
    frame_model_clear();
  endtask

  // One clock: apply inputs at the falling edge, then check this cycle's outputs.
  task automatic cycle(input logic rdy, input logic st);
    bit pop, done_next, accept;
    logic [2:0] mk;
    @(negedge clk);
    bus.px_ready = rdy;
    start        = st;
    #1;
    cyc++;
    chk("frame_done", 32'(frame_done), 32'(done_m));
    chk("busy", 32'(busy), 32'(busy_m));
    if (frame_done === 1'b1) saw_done = 1;
    if (bus.fb_rd_en === 1'b1) begin
      chk("read_allowed", 32'(busy_m && (iss < TOTAL)), 32'd1);
      chk("fb_addr", 32'(bus.fb_addr), 32'(iss));
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      iss++;
      chk("credit_limit", 32'((iss - popd) <= FIFO_DEPTH), 32'd1);
    end
    mk = {bus.px_sof, bus.px_eol, bus.px_eof};
    if (!busy_m) chk("idle_no_pixel", 32'(bus.px_valid), 32'd0);
    if (bus.px_valid !== 1'b1) chk("markers_gated", 32'(mk), 32'd0);
    if (prev_stall) begin
      chk("hold_valid", 32'(bus.px_valid), 32'd1);
      chk("hold_data", 32'(bus.px_data), 32'(prev_data));
      chk("hold_markers", 32'(mk), 32'(prev_mk));
    end
    if (bus.px_valid === 1'b1) begin
      if (first_valid < 0) begin
        first_valid = cyc;
        chk("first_px_latency", 32'(cyc - first_rd), 32'(RD_LAT + 1));
      end
      chk("pixel_in_frame", 32'(popd < TOTAL), 32'd1);
      chk("px_data", 32'(bus.px_data), 32'(popd + 'h100));
      chk("px_sof", 32'(bus.px_sof), 32'(popd == 0));
      chk("px_eol", 32'(bus.px_eol), 32'((popd % WIDTH) == WIDTH - 1));
      chk("px_eof", 32'(bus.px_eof), 32'(popd == TOTAL - 1));
    end
    pop        = (bus.px_valid === 1'b1) && rdy;
    prev_stall = (bus.px_valid === 1'b1) && !rdy;
    prev_data  = bus.px_data;
    prev_mk    = mk;
    if (pop) begin
      popd++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    done_next = pop && (popd == TOTAL);
    accept    = st && !busy_m;
    if (done_m) busy_m = 0;
    if (accept) begin
      busy_m = 1;
      frame_model_clear();
    end
    done_m = done_next;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; bus.px_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_fb_rd_en", 32'(bus.fb_rd_en), 32'd0);
    chk("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    chk("rst_px_valid", 32'(bus.px_valid), 32'd0);
    chk("rst_px_data", 32'(bus.px_data), 32'd0);
    chk("rst_markers", 32'({bus.px_sof, bus.px_eol, bus.px_eof}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    reset_model();
  endtask

  // mode 0: ready high, 1: ready toggles, 2: random ready.
  task automatic run_frame(input bit do_start, input int mode, input int restart_at);
    logic r;
    saw_done = 0;
    if (do_start) cycle(1'b1, 1'b1);
    for (int n = 0; n < 300 && !saw_done; n++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = n[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      cycle(r, n == restart_at);
    end
    chk("frame_completed", 32'(saw_done), 32'd1);
    chk("frame_pixels", 32'(popd), 32'(TOTAL));
    chk("frame_reads", 32'(iss), 32'(TOTAL));
  endtask

  initial begin
    bus.px_ready = 1'b0;
    reset_model();
    do_reset();

    // Full-rate frame.
    run_frame(1'b1, 0, -1);
    chk("s1_read_burst", 32'(last_rd - first_rd), 32'(TOTAL - 1));
    chk("s1_pixel_rate", 32'(last_pop - first_pop), 32'(TOTAL - 1));

    // Sink stalled: reads stop at the credit limit, head pixel stays put.
    cycle(1'b0, 1'b1);
    repeat (30) cycle(1'b0, 1'b0);
    chk("s2_reads_capped", 32'(iss), 32'(FIFO_DEPTH));
    chk("s2_rd_en_low", 32'(bus.fb_rd_en), 32'd0);
    chk("s2_head_pixel", 32'(bus.px_data), 32'h100);
    run_frame(1'b0, 0, -1);

    // Alternating backpressure.
    run_frame(1'b1, 1, -1);

    // Start pulse in the middle of a frame is ignored.
    run_frame(1'b1, 0, 3);
    chk("s4_pixel_rate", 32'(last_pop - first_pop), 32'(TOTAL - 1));

    // Reset with reads in flight, then replay.
    cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b1, 1'b0);
    do_reset();
    repeat (8) cycle(1'b1, 1'b0);
    run_frame(1'b1, 0, -1);

    // Back-to-back frames.
    run_frame(1'b1, 0, -1);
    run_frame(1'b1, 0, -1);

    // Random backpressure with stray start pulses.
    for (int f = 0; f < 4; f++) run_frame(1'b1, 2, int'($urandom_range(0, 12)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
`default_nettype wire
